// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write arbiter bus: host request channel,
// fill control/status and the registered RAM write port.
interface fb_write_arbiter_if #(
  parameter int WIDTH = 320,
  parameter int AW    = 8
);

  logic             host_req;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_data;
  logic             host_gnt;

  logic             fill_start;
  logic [WIDTH-1:0] fill_pattern;
  logic             fill_busy;
  logic             fill_done;

  logic             err_addr;

  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_data;
  logic             ram_we;

  modport master (
    output host_req,
    output host_addr,
    output host_data,
    input  host_gnt,
    output fill_start,
    output fill_pattern,
    input  fill_busy,
    input  fill_done,
    input  err_addr,
    input  ram_address,
    input  ram_data,
    input  ram_we
  );

  modport slave (
    input  host_req,
    input  host_addr,
    input  host_data,
    output host_gnt,
    input  fill_start,
    input  fill_pattern,
    output fill_busy,
    output fill_done,
    output err_addr,
    output ram_address,
    output ram_data,
    output ram_we
  );

endinterface

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: host line writes vs. a
// full-screen fill engine, alternating on contention.
module fb_write_arbiter #(
  parameter int LINES = 240,
  parameter int WIDTH = 320,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ram_clk,
  fb_write_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_t;

  typedef enum logic {
    WIN_FILL,
    WIN_HOST
  } winner_t;

  localparam logic [AW-1:0] LAST    = AW'(LINES - 1);
  localparam logic [AW:0]   LINES_W = (AW+1)'(LINES);

  fill_state_t      state;
  winner_t          last_winner;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] pattern;

  logic host_rq;
  logic fill_rq;
  logic host_only;
  logic fill_only;
  logic contested;
  logic host_win;
  logic fill_win;
  logic host_bad;

  assign ram_clk = clk;

  assign host_rq   = bus.host_req & ~rst;
  assign fill_rq   = (state == FILL);
  assign host_only = host_rq & ~fill_rq;
  assign fill_only = fill_rq & ~host_rq;
  assign contested = host_rq & fill_rq;
  assign host_bad  = ({1'b0, bus.host_addr} >= LINES_W);

  assign bus.host_gnt = host_win;

  // Pick at most one winner; contests go to whoever lost last time.
  always_comb begin
    host_win = 1'b0;
    fill_win = 1'b0;
    unique case (1'b1)
      host_only: host_win = 1'b1;
      fill_only: fill_win = 1'b1;
      contested: begin
        if (last_winner == WIN_FILL) begin
          host_win = 1'b1;
        end else begin
          fill_win = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Remember the winner of the most recent contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner <= WIN_FILL;
    end else if (contested) begin
      last_winner <= host_win ? WIN_HOST : WIN_FILL;
    end
  end

  // Fill engine: walk every line once, advancing only when granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fill_addr     <= '0;
      pattern       <= '0;
      bus.fill_busy <= 1'b0;
      bus.fill_done <= 1'b0;
    end else begin
      bus.fill_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.fill_start) begin
            state         <= FILL;
            fill_addr     <= '0;
            pattern       <= bus.fill_pattern;
            bus.fill_busy <= 1'b1;
          end
        end
        FILL: begin
          if (fill_win) begin
            if (fill_addr == LAST) begin
              state         <= IDLE;
              bus.fill_busy <= 1'b0;
              bus.fill_done <= 1'b1;
            end else begin
              fill_addr <= fill_addr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port register; out-of-range host writes only flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ram_we      <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      bus.err_addr    <= 1'b0;
    end else begin
      bus.ram_we   <= 1'b0;
      bus.err_addr <= 1'b0;
      if (host_win) begin
        if (host_bad) begin
          bus.err_addr <= 1'b1;
        end else begin
          bus.ram_we      <= 1'b1;
          bus.ram_address <= bus.host_addr;
          bus.ram_data    <= bus.host_data;
        end
      end else if (fill_win) begin
        bus.ram_we      <= 1'b1;
        bus.ram_address <= fill_addr;
        bus.ram_data    <= pattern;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: host, fill,
// contention, bad address, restart and mid-fill reset.
module tb_fb_write_arbiter;

  localparam int LINES = 240;
  localparam int WIDTH = 320;
  localparam int AW    = 8;

  logic clk;
  logic rst;
  logic ram_clk;

  int n_run;
  int n_fail;

  fb_write_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fb_write_arbiter #(
    .LINES(LINES),
    .WIDTH(WIDTH),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ram_clk(ram_clk),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [319:0] got,
    input logic [319:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   320'(bus.ram_we), 320'd0);
    chk({tag, "_addr"}, 320'(bus.ram_address), 320'd0);
    chk({tag, "_data"}, bus.ram_data, 320'd0);
    chk({tag, "_busy"}, 320'(bus.fill_busy), 320'd0);
    chk({tag, "_done"}, 320'(bus.fill_done), 320'd0);
    chk({tag, "_err"},  320'(bus.err_addr), 320'd0);
    chk({tag, "_gnt"},  320'(bus.host_gnt), 320'd0);
  endtask

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] p_aa;
  logic [WIDTH-1:0] p_55;
  logic [WIDTH-1:0] p_c3;
  logic [WIDTH-1:0] p_3c;
  logic [WIDTH-1:0] hdat;

  initial begin
    int  hi;
    int  f;
    bit  exp_h;
    bit  gnt_s;
    int  n_we;
    int  n_done;
    int  n_busy;

    n_run  = 0;
    n_fail = 0;
    ones = '1;
    p_aa = {40{8'hAA}};
    p_55 = {40{8'h55}};
    p_c3 = {40{8'hC3}};
    p_3c = {40{8'h3C}};

    rst              = 1'b0;
    bus.host_req     = 1'b0;
    bus.host_addr    = '0;
    bus.host_data    = '0;
    bus.fill_start   = 1'b0;
    bus.fill_pattern = '0;

    // reset, with a host request pending
    #2;
    rst          = 1'b1;
    bus.host_req = 1'b1;
    bus.host_addr = 8'd1;
    #1;
    chk_zero("rst");
    tick();
    tick();
    chk_zero("rst_hold");
    chk("ramclk", 320'(ram_clk), 320'(clk));
    bus.host_req = 1'b0;
    rst = 1'b0;
    tick();

    // host-only write
    bus.host_req  = 1'b1;
    bus.host_addr = 8'd5;
    bus.host_data = ones;
    #1;
    chk("h_gnt", 320'(bus.host_gnt), 320'd1);
    tick();
    chk("h_we", 320'(bus.ram_we), 320'd1);
    chk("h_addr", 320'(bus.ram_address), 320'd5);
    chk("h_data", bus.ram_data, ones);
    chk("h_err", 320'(bus.err_addr), 320'd0);
    bus.host_req = 1'b0;
    #1;
    chk("h_gnt0", 320'(bus.host_gnt), 320'd0);
    tick();
    chk("h_we0", 320'(bus.ram_we), 320'd0);
    chk("h_hold", 320'(bus.ram_address), 320'd5);

    // out-of-range host address
    bus.host_req  = 1'b1;
    bus.host_addr = 8'd240;
    bus.host_data = p_3c;
    #1;
    chk("bad_gnt", 320'(bus.host_gnt), 320'd1);
    tick();
    chk("bad_err", 320'(bus.err_addr), 320'd1);
    chk("bad_we", 320'(bus.ram_we), 320'd0);
    chk("bad_addr", 320'(bus.ram_address), 320'd5);
    chk("bad_data", bus.ram_data, ones);
    bus.host_req = 1'b0;
    tick();
    chk("bad_err0", 320'(bus.err_addr), 320'd0);

    // fill only
    bus.fill_start   = 1'b1;
    bus.fill_pattern = p_aa;
    tick();
    bus.fill_start   = 1'b0;
    bus.fill_pattern = '0;
    chk("f_busy", 320'(bus.fill_busy), 320'd1);
    chk("f_we0", 320'(bus.ram_we), 320'd0);
    for (int i = 0; i < LINES; i++) begin
      tick();
      chk("f_we", 320'(bus.ram_we), 320'd1);
      chk("f_addr", 320'(bus.ram_address), 320'(i));
      chk("f_data", bus.ram_data, p_aa);
      chk("f_done", 320'(bus.fill_done), 320'(i == LINES - 1));
      chk("f_busyi", 320'(bus.fill_busy), 320'(i != LINES - 1));
    end
    tick();
    chk("f_end_we", 320'(bus.ram_we), 320'd0);
    chk("f_end_done", 320'(bus.fill_done), 320'd0);

    // contention: host 10,11,12 held against a running fill
    bus.fill_start   = 1'b1;
    bus.fill_pattern = p_55;
    tick();
    bus.fill_start = 1'b0;
    hi = 0;
    for (int k = 0; k < 243; k++) begin
      bus.host_req  = (hi < 3);
      bus.host_addr = AW'(10 + hi);
      hdat = {10{32'hC0DE_0000 | 32'(hi)}};
      bus.host_data = hdat;
      #1;
      exp_h = (k == 0) || (k == 2) || (k == 4);
      gnt_s = bus.host_gnt;
      chk("c_gnt", 320'(gnt_s), 320'(exp_h));
      tick();
      chk("c_we", 320'(bus.ram_we), 320'd1);
      if (exp_h) begin
        chk("c_haddr", 320'(bus.ram_address), 320'(10 + k / 2));
        chk("c_hdata", bus.ram_data, hdat);
      end else begin
        f = (k < 6) ? (k - 1) / 2 : k - 3;
        chk("c_faddr", 320'(bus.ram_address), 320'(f));
        chk("c_fdata", bus.ram_data, p_55);
      end
      chk("c_done", 320'(bus.fill_done), 320'(k == 242));
      if (gnt_s) hi++;
    end
    bus.host_req = 1'b0;
    chk("c_busy_end", 320'(bus.fill_busy), 320'd0);

    // fill_start with host_req while idle, restart, reset
    bus.fill_start   = 1'b1;
    bus.fill_pattern = p_c3;
    bus.host_req     = 1'b1;
    bus.host_addr    = 8'd7;
    bus.host_data    = p_3c;
    #1;
    chk("s_gnt", 320'(bus.host_gnt), 320'd1);
    tick();
    bus.fill_start   = 1'b0;
    bus.fill_pattern = '0;
    bus.host_req     = 1'b0;
    chk("s_addr", 320'(bus.ram_address), 320'd7);
    chk("s_data", bus.ram_data, p_3c);
    chk("s_busy", 320'(bus.fill_busy), 320'd1);
    for (int i = 0; i < 100; i++) tick();
    chk("r_addr99", 320'(bus.ram_address), 320'd99);
    bus.fill_start   = 1'b1;
    bus.fill_pattern = p_aa;
    tick();
    bus.fill_start = 1'b0;
    chk("r_addr100", 320'(bus.ram_address), 320'd100);
    chk("r_data", bus.ram_data, p_c3);
    chk("r_busy", 320'(bus.fill_busy), 320'd1);
    for (int i = 0; i < 49; i++) tick();
    chk("r_addr149", 320'(bus.ram_address), 320'd149);
    bus.host_req  = 1'b1;
    bus.host_addr = 8'd3;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick();
    bus.host_req = 1'b0;
    rst = 1'b0;
    n_we   = 0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_we   += int'(bus.ram_we);
      n_done += int'(bus.fill_done);
      n_busy += int'(bus.fill_busy);
    end
    chk("post_we", 320'(n_we), 320'd0);
    chk("post_done", 320'(n_done), 320'd0);
    chk("post_busy", 320'(n_busy), 320'd0);

    // host write still works after the aborted fill
    bus.host_req  = 1'b1;
    bus.host_addr = 8'd239;
    bus.host_data = p_55;
    #1;
    chk("post_gnt", 320'(bus.host_gnt), 320'd1);
    tick();
    bus.host_req = 1'b0;
    chk("post_addr", 320'(bus.ram_address), 320'd239);
    chk("post_data", bus.ram_data, p_55);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter LINES, default 240, number of framebuffer lines (valid addresses 0..LINES-1).
REQ-002 Parameter WIDTH, default 320, bits per line word.
REQ-003 Parameter AW, default 8, line-address width.
REQ-004 clk  in  1  single clock for all logic; also drives ram_clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 host_req  in  1  host requests a one-line write; holds host_addr/host_data stable until accepted.
REQ-007 host_addr  in  AW  host target line.
REQ-008 host_data  in  WIDTH  host line data.
REQ-009 host_gnt  out  1  combinational accept; transfer occurs on the edge where host_req && host_gnt.
REQ-010 fill_start  in  1  one-cycle pulse starting a fill of all lines.
REQ-011 fill_pattern  in  WIDTH  fill word, sampled with fill_start.
REQ-012 fill_busy  out  1  fill in progress.
REQ-013 fill_done  out  1  one-cycle pulse on the final fill write.
REQ-014 err_addr  out  1  registered one-cycle pulse: accepted host write had host_addr >= LINES.
REQ-015 ram_address  out  AW  registered RAM write address.
REQ-016 ram_data  out  WIDTH  registered RAM write data.
REQ-017 ram_we  out  1  registered RAM write enable.
REQ-018 ram_clk  out  1  equals clk.

Function
REQ-019 Two requesters share the RAM write port: host (when host_req=1) and fill engine (when fill_busy=1); at most one grant per cycle.
REQ-020 Only one requesting: it wins.
REQ-021 Both requesting: winner is the requester not granted on the most recent contested cycle; last_winner resets to fill, so host wins the first contest.
REQ-022 Fill engine states: IDLE, FILL.
REQ-023 IDLE -> FILL on fill_start: fill_addr <= 0, pattern register <= fill_pattern, fill_busy <= 1.
REQ-024 fill_start while in FILL is ignored; pattern and fill_addr are unchanged.
REQ-025 In FILL, each fill grant writes pattern to fill_addr, then fill_addr increments; the grant at fill_addr = LINES-1 returns to IDLE.
REQ-026 Fill produces exactly LINES writes, addresses 0..LINES-1 ascending, no skips or repeats, regardless of host interleaving.
REQ-027 Any grant updates ram_address/ram_data/ram_we on the same edge (one-cycle latency from grant to ram_we=1); no grant -> ram_we <= 0, ram_address/ram_data hold.
REQ-028 Final fill grant: ram_we=1 with ram_address=LINES-1, fill_done=1 and fill_busy=0, all in the same cycle.
REQ-029 Host grant with host_addr >= LINES: request consumed (host_gnt=1), ram_we <= 0, err_addr <= 1.
REQ-030 fill_start and host_req in the same cycle while IDLE: host is granted that cycle; fill requests from the next cycle.
REQ-031 host_gnt=0 whenever the fill engine wins arbitration.

Reset
REQ-032 rst=1 asynchronously forces: ram_we=0, ram_address=0, ram_data=0, fill_busy=0, fill_done=0, err_addr=0, fill_addr=0, pattern=0, state IDLE, last_winner=fill; host_gnt=0 while rst=1.
REQ-033 Reset mid-fill aborts the fill; no further fill writes and no fill_done after release.

Verification
REQ-034 Host-only: host_req=1, addr 5, data all-ones -> host_gnt=1 that cycle, next cycle ram_we=1, ram_address=5, ram_data all-ones.
REQ-035 Fill-only: fill_start pulse, fill_pattern=0xAA..AA -> 240 consecutive ram_we cycles, addresses 0..239; fill_done=1 and fill_busy falls together with address 239.
REQ-036 Contention: fill in progress, host_req held continuously with addresses 10,11,12 -> grants alternate host/fill; fill still covers 0..239 exactly once; fill_done after 243 write cycles.
REQ-037 Bad address: host_addr=240 -> host_gnt=1, err_addr=1 next cycle, ram_we=0.
REQ-038 Restart and reset: fill_start again at fill_addr=100 -> ignored; rst at fill_addr=150 -> all outputs 0 immediately, no writes or fill_done after release.
